lcd_frame_writer: RTL and testbench
===================================

// Module: lcd_frame_writer
// PURPOSE
//  Sequencer for the 16x2 HD44780-style character LCD that shows the hangman
//  display rows. Runs the LCD power-up/init command sequence, then on each
//  update request snapshots the two 128-bit row buffers and writes all 32
//  characters. Sits between the display-row generator and the LCD pins.
//  Write-only bus, 8-bit mode.
// PARAMETERS
//  POWERUP_CYC  200000  idle cycles after reset before the first command
//  EN_CYC       10      cycles lcd_en is held high per byte
//  WAIT_CYC     500     cycles lcd_en is held low after each normal byte
//  CLEAR_CYC    20000   cycles lcd_en is held low after the clear command (0x01)
// PORTS
//  clk        in   1    system clock; the only clock
//  rst        in   1    synchronous, active-high reset
//  row1       in   128  top line; [127:120] = column 0 ... [7:0] = column 15
//  row2       in   128  bottom line; same byte ordering
//  update     in   1    one-cycle request to redraw both lines
//  busy       out  1    high during init or while a frame is being written
//  lcd_rs     out  1    0 = command, 1 = character data
//  lcd_rw     out  1    tied 0 (write only)
//  lcd_en     out  1    LCD enable strobe
//  lcd_data   out  8    LCD data bus
// BEHAVIOUR
//  - Clocking and reset: one clock; reset is synchronous and active-high.
//    While rst=1: state=PWRUP, counters=0, pending=0, busy=1, lcd_en=0,
//    lcd_rs=0, lcd_rw=0, lcd_data=8'h00.
//    Reset mid-frame aborts the write immediately. The full init sequence reruns.
//  - Byte write slot (shared by commands and characters):
//    - SETUP, 1 cycle: drive lcd_rs and lcd_data, en=0.
//    - PULSE, EN_CYC cycles: en=1.
//    - HOLD, WAIT_CYC cycles (CLEAR_CYC for 0x01): en=0.
//    - rs and data stay stable from SETUP through the end of HOLD.
//    - Slot length = 1 + EN_CYC + hold.
//  - FSM:
//    - PWRUP: count POWERUP_CYC cycles -> INIT.
//    - INIT: slots for 0x38, 0x0C, 0x06, 0x01 (rs=0) -> IDLE.
//    - IDLE: busy=0, en=0. On update=1 or pending=1: clear pending,
//      capture row1/row2 into a frame snapshot, then -> ADDR1.
//    - ADDR1: cmd 0x80 -> LINE1 (16 char slots, column 0 first).
//    - ADDR2: cmd 0xC0 -> LINE2 (16 char slots) -> IDLE.
//    - A frame is 34 slots.
//  - Character mapping: snapshot byte 8'h00 is sent as 8'h20 (space).
//    All other bytes are sent unchanged.
//  - Snapshot rule: row inputs are sampled only in the IDLE->ADDR1 cycle.
//    Input changes mid-frame do not affect the frame in flight.
//  - update while busy (init or frame): sets pending.
//    - Multiple requests collapse into one.
//    - After the current frame or init ends, IDLE lasts exactly 1 cycle
//      (busy=0), then the next frame starts with the rows present at that time.
//  - update arriving in the same cycle that the FSM enters IDLE is recorded
//    as pending. It is never dropped.
//  - busy=1 in every state except IDLE. It is registered, with no combinational
//    path from update.
//  - Counters are sized for the largest parameter. They reset to 0 at every
//    phase boundary. There is no wrap-around inside a phase.
// TESTING (POWERUP_CYC=20, EN_CYC=2, WAIT_CYC=3, CLEAR_CYC=10; slot=6, clear slot=13)
//  - Release rst -> en stays 0 for 20 cycles.
//    Then en pulses carry 0x38, 0x0C, 0x06, 0x01 with rs=0.
//    busy falls 51 cycles after rst release.
//  - row1 = "HANGMAN" followed by 9 zero bytes, row2 = 16 x "_", then pulse update:
//    - rs=0, 0x80
//    - rs=1 bytes: 48 41 4E 47 4D 41 4E, then nine 0x20
//    - rs=0, 0xC0
//    - sixteen 0x5F
//    - 34 en pulses total; busy high for 204 cycles.
//  - Change row1 to all 0x41 mid-frame -> the rest of the frame still sends the
//    original snapshot. A later update sends the 0x41 bytes.
//  - Pulse update 3 times during one frame -> exactly one extra frame follows,
//    after a 1-cycle IDLE.
//  - Assert rst at char slot 10 of LINE1 -> next cycle en=0, data=0, busy=1.
//    The full init sequence repeats before any character is written.
//  - Pulse update during PWRUP -> first frame starts 1 cycle after init
//    completes. lcd_rw stays 0 for the whole test.

Source files
------------

// File: rtl/lcd_frame_writer.sv
// Drives a 16x2 HD44780-style LCD in 8-bit write-only mode: runs the power-up/init
// command sequence, then redraws both lines from a snapshot on every update request.
module lcd_frame_writer #(
  parameter int POWERUP_CYC = 200000,
  parameter int EN_CYC      = 10,
  parameter int WAIT_CYC    = 500,
  parameter int CLEAR_CYC   = 20000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] row1,
  input  logic [127:0] row2,
  input  logic         update,
  output logic         busy,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic [7:0]   lcd_data
);

  localparam int MAX_AB = (POWERUP_CYC > EN_CYC) ? POWERUP_CYC : EN_CYC;
  localparam int MAX_CD = (WAIT_CYC > CLEAR_CYC) ? WAIT_CYC : CLEAR_CYC;
  localparam int MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] PWR_LAST   = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYC - 1);

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, ADDR1, LINE1, ADDR2, LINE2} state_t;
  typedef enum logic [1:0] {SETUP, PULSE, HOLD} phase_t;

  state_t         state_reg;
  phase_t         phase_reg;
  logic [CW-1:0]  cnt_reg;
  logic [3:0]     idx_reg;
  logic           pending_reg;
  logic [127:0]   snap1_reg;
  logic [127:0]   snap2_reg;

  state_t         nxt_state;
  logic [3:0]     nxt_idx;
  logic           nxt_rs;
  logic [7:0]     nxt_data;
  logic           nxt_idle;
  logic [CW-1:0]  hold_last;

  // Column 0 lives in the top byte; a null byte is shown as a space.
  function automatic logic [7:0] char_at(input logic [127:0] row, input logic [3:0] col);
    logic [6:0] base;
    logic [7:0] b;
    base = {~col, 3'b000};
    b    = row[base +: 8];
    return (b == 8'h00) ? 8'h20 : b;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  assign lcd_rw    = 1'b0;
  assign hold_last = (!lcd_rs && lcd_data == 8'h01) ? CLEAR_LAST : WAIT_LAST;

  // What to put on the bus once the current slot's hold phase finishes.
  always_comb begin
    nxt_state = state_reg;
    nxt_idx   = idx_reg;
    nxt_rs    = 1'b0;
    nxt_data  = 8'h00;
    nxt_idle  = 1'b0;
    case (state_reg)
      INIT: begin
        if (idx_reg == 4'd3) nxt_idle = 1'b1;
        else begin
          nxt_idx  = idx_reg + 4'd1;
          nxt_data = init_cmd(idx_reg[1:0] + 2'd1);
        end
      end
      ADDR1: begin
        nxt_state = LINE1;
        nxt_idx   = 4'd0;
        nxt_rs    = 1'b1;
        nxt_data  = char_at(snap1_reg, 4'd0);
      end
      LINE1: begin
        if (idx_reg == 4'd15) begin
          nxt_state = ADDR2;
          nxt_idx   = 4'd0;
          nxt_data  = 8'hC0;
        end else begin
          nxt_idx  = idx_reg + 4'd1;
          nxt_rs   = 1'b1;
          nxt_data = char_at(snap1_reg, idx_reg + 4'd1);
        end
      end
      ADDR2: begin
        nxt_state = LINE2;
        nxt_idx   = 4'd0;
        nxt_rs    = 1'b1;
        nxt_data  = char_at(snap2_reg, 4'd0);
      end
      LINE2: begin
        if (idx_reg == 4'd15) nxt_idle = 1'b1;
        else begin
          nxt_idx  = idx_reg + 4'd1;
          nxt_rs   = 1'b1;
          nxt_data = char_at(snap2_reg, idx_reg + 4'd1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= PWRUP;
      phase_reg   <= SETUP;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      pending_reg <= 1'b0;
      snap1_reg   <= '0;
      snap2_reg   <= '0;
      busy        <= 1'b1;
      lcd_en      <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_data    <= 8'h00;
    end else begin
      if (state_reg != IDLE && update) pending_reg <= 1'b1;
      case (state_reg)
        PWRUP: begin
          if (cnt_reg == PWR_LAST) begin
            state_reg <= INIT;
            phase_reg <= SETUP;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h38;
          end else cnt_reg <= cnt_reg + 1'b1;
        end
        IDLE: begin
          pending_reg <= 1'b0;
          if (update || pending_reg) begin
            snap1_reg <= row1;
            snap2_reg <= row2;
            state_reg <= ADDR1;
            phase_reg <= SETUP;
            cnt_reg   <= '0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h80;
            busy      <= 1'b1;
          end
        end
        default: begin
          case (phase_reg)
            SETUP: begin
              phase_reg <= PULSE;
              lcd_en    <= 1'b1;
              cnt_reg   <= '0;
            end
            PULSE: begin
              if (cnt_reg == EN_LAST) begin
                phase_reg <= HOLD;
                lcd_en    <= 1'b0;
                cnt_reg   <= '0;
              end else cnt_reg <= cnt_reg + 1'b1;
            end
            default: begin
              if (cnt_reg == hold_last) begin
                cnt_reg <= '0;
                if (nxt_idle) begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
                end else begin
                  state_reg <= nxt_state;
                  idx_reg   <= nxt_idx;
                  phase_reg <= SETUP;
                  lcd_rs    <= nxt_rs;
                  lcd_data  <= nxt_data;
                end
              end else cnt_reg <= cnt_reg + 1'b1;
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Bench for lcd_frame_writer: slot-queue reference model checked every cycle,
// plus literal expectations for init timing, the HANGMAN frame and edge cases.
module tb_lcd_frame_writer;
  localparam int PW = 20, EN = 2, WT = 3, CL = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         update = 1'b0;
  logic [127:0] row1 = '0;
  logic [127:0] row2 = '0;
  logic         busy, lcd_rs, lcd_rw, lcd_en;
  logic [7:0]   lcd_data;

  lcd_frame_writer #(.POWERUP_CYC(PW), .EN_CYC(EN), .WAIT_CYC(WT), .CLEAR_CYC(CL)) dut (
    .clk(clk), .rst(rst), .row1(row1), .row2(row2), .update(update),
    .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending byte slots, each with its full length.
  typedef struct { bit rs; bit [7:0] d; int len; } slot_t;
  slot_t q[$];
  int    pw_left = PW;
  int    pos = 0;
  bit    pend = 0;
  bit    mvalid = 0;

  function automatic void push_slot(input bit rs, input bit [7:0] d);
    slot_t s;
    s.rs  = rs;
    s.d   = d;
    s.len = 1 + EN + ((!rs && d == 8'h01) ? CL : WT);
    q.push_back(s);
  endfunction

  function automatic bit [7:0] mapc(input bit [7:0] b);
    return (b == 8'h00) ? 8'h20 : b;
  endfunction

  function automatic void push_frame(input bit [127:0] r1, input bit [127:0] r2);
    push_slot(1'b0, 8'h80);
    for (int c = 0; c < 16; c++) push_slot(1'b1, mapc(r1[8*(15-c) +: 8]));
    push_slot(1'b0, 8'hC0);
    for (int c = 0; c < 16; c++) push_slot(1'b1, mapc(r2[8*(15-c) +: 8]));
  endfunction

  always @(posedge clk) begin
    bit bb;
    if (rst) begin
      pw_left = PW; q.delete(); pos = 0; pend = 0; mvalid = 1;
    end else if (mvalid) begin
      bb = (pw_left > 0) || (q.size() > 0);
      if (bb && update) pend = 1;
      if (pw_left > 0) begin
        pw_left--;
        if (pw_left == 0) begin
          push_slot(1'b0, 8'h38); push_slot(1'b0, 8'h0C);
          push_slot(1'b0, 8'h06); push_slot(1'b0, 8'h01);
        end
      end else if (q.size() > 0) begin
        pos++;
        if (pos == q[0].len) begin
          void'(q.pop_front());
          pos = 0;
        end
      end else if (update || pend) begin
        pend = 0;
        push_frame(row1, row2);
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("busy", busy, (pw_left > 0 || q.size() > 0) ? 1 : 0);
      chk("en", lcd_en, (q.size() > 0 && pos >= 1 && pos <= EN) ? 1 : 0);
      chk("rw", lcd_rw, 0);
      if (q.size() > 0) begin
        chk("rs", lcd_rs, q[0].rs);
        chk("data", lcd_data, q[0].d);
      end else if (pw_left > 0) begin
        chk("rs_pwr", lcd_rs, 0);
        chk("data_pwr", lcd_data, 0);
      end
    end
  end

  // Capture every enable pulse as {rs, data} at its rising edge.
  bit [8:0] cap[$];
  logic     en_d = 1'b0;
  always @(negedge clk) begin
    if (lcd_en === 1'b1 && en_d !== 1'b1) cap.push_back({lcd_rs, lcd_data});
    en_d = lcd_en;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_update();
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_busy(input logic v, input int maxc, input string nm, output int n);
    n = 0;
    while (busy !== v && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (busy !== v) begin
      total++; bad++;
      $display("FAIL %s: timeout, busy=%b want %b", nm, busy, v);
    end
  endtask

  function automatic bit [127:0] rand_row();
    bit [127:0] r;
    bit [7:0]   b;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h01) b = 8'h00;
      r[8*i +: 8] = b;
    end
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit [8:0] exp_frame[34];
    bit [55:0] hang;

    tick(3);
    chk("rst_busy", busy, 1);
    chk("rst_en", lcd_en, 0);
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_rs", lcd_rs, 0);

    // Power-up and init sequence.
    cap.delete();
    rst = 1'b0;
    wait_busy(1'b0, 1000, "init_wait", n);
    chk("init_len", n, 51);
    chk("init_cnt", cap.size(), 4);
    chk("init0", cap[0], {1'b0, 8'h38});
    chk("init1", cap[1], {1'b0, 8'h0C});
    chk("init2", cap[2], {1'b0, 8'h06});
    chk("init3", cap[3], {1'b0, 8'h01});

    // HANGMAN frame.
    hang = "HANGMAN";
    row1 = {hang, 72'h0};
    row2 = {16{8'h5F}};
    exp_frame[0] = {1'b0, 8'h80};
    for (int i = 0; i < 7; i++) exp_frame[1+i] = {1'b1, hang[8*(6-i) +: 8]};
    for (int i = 7; i < 16; i++) exp_frame[1+i] = {1'b1, 8'h20};
    exp_frame[17] = {1'b0, 8'hC0};
    for (int i = 0; i < 16; i++) exp_frame[18+i] = {1'b1, 8'h5F};
    tick(2);
    cap.delete();
    pulse_update();
    wait_busy(1'b0, 1000, "frame_wait", n);
    chk("frame_busy_len", n, 204);
    chk("frame_pulses", cap.size(), 34);
    for (int i = 0; i < 34; i++) chk($sformatf("frame_b%0d", i), cap[i], exp_frame[i]);

    // Mid-frame row change must not affect the frame in flight.
    tick(2);
    cap.delete();
    pulse_update();
    tick(60);
    row1 = {16{8'h41}};
    wait_busy(1'b0, 1000, "snap_wait", n);
    chk("snap_col0", cap[1], {1'b1, 8'h48});
    chk("snap_col7", cap[8], {1'b1, 8'h20});
    tick(2);
    cap.delete();
    pulse_update();
    wait_busy(1'b0, 1000, "snap2_wait", n);
    chk("new_col0", cap[1], {1'b1, 8'h41});
    chk("new_col15", cap[16], {1'b1, 8'h41});

    // Three requests during one frame collapse into one extra frame.
    tick(2);
    cap.delete();
    pulse_update();
    tick(20); pulse_update();
    tick(40); pulse_update();
    tick(40); pulse_update();
    wait_busy(1'b0, 1000, "multi_wait", n);
    @(negedge clk);
    chk("idle_one_cycle", busy, 1);
    wait_busy(1'b0, 1000, "multi_wait2", n);
    chk("multi_pulses", cap.size(), 68);
    tick(3);
    chk("no_third_frame", busy, 0);

    // Randomized traffic: updates at random times, rows changing underneath.
    for (int r = 0; r < 6; r++) begin
      row1 = rand_row();
      row2 = rand_row();
      for (int c = 0; c < 400; c++) begin
        update = ($urandom_range(0, 99) < 2);
        if ($urandom_range(0, 99) < 3) row1 = rand_row();
        if ($urandom_range(0, 99) < 3) row2 = rand_row();
        @(negedge clk);
      end
      update = 1'b0;
      wait_busy(1'b0, 2000, "rand_wait", n);
      tick(1);
    end

    // Reset in the middle of LINE1 character slot 10.
    cap.delete();
    pulse_update();
    n = 0;
    while (cap.size() < 12 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_slot10", cap.size(), 12);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_en", lcd_en, 0);
    chk("abort_data", lcd_data, 8'h00);
    chk("abort_busy", busy, 1);
    tick(2);

    // Update during power-up: frame follows init after one idle cycle.
    cap.delete();
    rst = 1'b0;
    tick(5);
    pulse_update();
    wait_busy(1'b0, 1000, "pwr_upd_wait", n);
    chk("pwr_upd_idle_at", n, 45);
    @(negedge clk);
    chk("pwr_upd_frame_start", busy, 1);
    wait_busy(1'b0, 1000, "pwr_upd_frame", n);
    chk("pwr_upd_pulses", cap.size(), 38);
    chk("pwr_upd_clear", cap[3], {1'b0, 8'h01});
    chk("pwr_upd_addr", cap[4], {1'b0, 8'h80});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
